// File: rtl/tpu_host_sequencer.sv
// rtl/tpu_host_sequencer.sv - bus initiator that runs one TPU matrix job
// Loads A, B and C, triggers the multiply, waits it out, then streams the C result back.
module tpu_host_sequencer #(
  parameter int DIM      = 8,
  parameter int DATAW    = 64,
  parameter int ADDRW    = 16,
  parameter int MUL_WAIT = 3*DIM-1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DATAW-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DATAW-1:0] out_data,
  output logic             bus_r_w,
  output logic [ADDRW-1:0] bus_addr,
  output logic [DATAW-1:0] bus_wdata,
  input  logic [DATAW-1:0] bus_rdata
);

  localparam int CW = $clog2(2*DIM) + 1;
  localparam int WW = $clog2(MUL_WAIT) + 1;

  localparam logic [CW-1:0] ROW_LAST = CW'(DIM - 1);
  localparam logic [CW-1:0] C_WORDS  = CW'(2*DIM);
  localparam logic [CW-1:0] C_LAST   = CW'(2*DIM - 1);
  localparam logic [WW-1:0] W_LAST   = WW'(MUL_WAIT - 1);

  localparam logic [ADDRW-1:0] A_BASE    = ADDRW'(16'h0100);
  localparam logic [ADDRW-1:0] B_BASE    = ADDRW'(16'h0200);
  localparam logic [ADDRW-1:0] C_BASE    = ADDRW'(16'h0300);
  localparam logic [ADDRW-1:0] TRIG_ADDR = ADDRW'(16'h0400);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_LOAD_C,
    S_C_GAP,
    S_TRIGGER,
    S_WAIT_MUL,
    S_READ_C,
    S_DONE
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [WW-1:0]   wcnt;
  logic            wr_fire;
  logic            rd_issue;
  logic            out_accept;
  logic [ADDRW-1:0] base;
  logic [ADDRW-1:0] word_off;

  assign in_ready   = (state == S_LOAD_A) || (state == S_LOAD_B) || (state == S_LOAD_C);
  assign busy       = (state != S_IDLE);
  assign wr_fire    = in_ready && in_valid;
  assign out_accept = out_valid && out_ready;
  // A read may only be issued when the output register will be free at the next edge.
  assign rd_issue   = (state == S_READ_C) && (!out_valid || out_ready);
  assign done       = (state == S_DONE) && out_accept;
  assign word_off   = ADDRW'({cnt, 3'b000});

  always_comb begin
    case (state)
      S_LOAD_A: base = A_BASE;
      S_LOAD_B: base = B_BASE;
      default:  base = C_BASE;
    endcase
  end

  // Bus cycles follow the handshake combinationally; every other cycle is an idle cycle.
  always_comb begin
    bus_r_w   = 1'b0;
    bus_addr  = '0;
    bus_wdata = '0;
    if (wr_fire) begin
      bus_r_w   = 1'b1;
      bus_addr  = base + word_off;
      bus_wdata = in_data;
    end else if (state == S_TRIGGER) begin
      bus_r_w  = 1'b1;
      bus_addr = TRIG_ADDR;
    end else if (rd_issue) begin
      bus_addr = base + word_off;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      wcnt      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (rd_issue) begin
        out_valid <= 1'b1;
        out_data  <= bus_rdata;
      end else if (out_accept) begin
        out_valid <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_LOAD_A;
            cnt   <= '0;
            wcnt  <= '0;
          end
        end
        S_LOAD_A: begin
          if (wr_fire) begin
            if (cnt == ROW_LAST) begin
              cnt   <= '0;
              state <= S_LOAD_B;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        S_LOAD_B: begin
          if (wr_fire) begin
            if (cnt == ROW_LAST) begin
              cnt   <= '0;
              state <= S_LOAD_C;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        S_LOAD_C: begin
          if (wr_fire) begin
            cnt   <= cnt + 1'b1;
            state <= S_C_GAP;
          end
        end
        // The TPU commits the C half-row during this idle cycle.
        S_C_GAP: begin
          if (cnt == C_WORDS) begin
            cnt   <= '0;
            state <= S_TRIGGER;
          end else begin
            state <= S_LOAD_C;
          end
        end
        S_TRIGGER: begin
          wcnt  <= '0;
          state <= S_WAIT_MUL;
        end
        S_WAIT_MUL: begin
          if (wcnt == W_LAST) begin
            wcnt  <= '0;
            state <= S_READ_C;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        S_READ_C: begin
          if (rd_issue) begin
            if (cnt == C_LAST) begin
              cnt   <= '0;
              state <= S_DONE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        S_DONE: begin
          if (out_accept) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tpu_host_sequencer.sv
// tb/tb_tpu_host_sequencer.sv - self-checking bench for tpu_host_sequencer
// Includes a behavioural TPU (int8 A/B rows, int16 C lanes) on the bus.
module tb_tpu_host_sequencer;
  localparam int DIM      = 8;
  localparam int MUL_WAIT = 3*DIM-1;
  localparam int NW       = 4*DIM;

  typedef logic [63:0] mat_t [DIM];
  typedef logic [63:0] cw_t [2*DIM];
  typedef struct packed {logic rw; logic [15:0] addr; logic [63:0] wdata;} tx_t;
  typedef struct packed {
    logic rw; logic [15:0] addr; logic [63:0] wdata;
    logic iv; logic ov; logic ordy; logic [63:0] od; logic dn; logic by;
  } cyc_t;
  typedef struct {
    logic start; logic iv; logic [63:0] data;
    logic by; logic ir; logic rw; logic [15:0] addr; logic [63:0] wdata;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        busy, done, in_ready, out_valid, bus_r_w;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [63:0] in_data = '0;
  logic [63:0] out_data, bus_wdata, bus_rdata;
  logic [15:0] bus_addr;

  int total = 0;
  int bad = 0;

  cyc_t        log_q[$];
  logic [63:0] acc_q[$];

  tpu_host_sequencer #(.DIM(DIM), .DATAW(64), .ADDRW(16), .MUL_WAIT(MUL_WAIT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .bus_r_w(bus_r_w), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // C[r][c] += sum_k A[r][k]*B[k][c], int8 operands, int16 wrap-around lanes.
  function automatic cw_t matmul(input mat_t a, input mat_t b, input cw_t c);
    cw_t res;
    for (int w = 0; w < 2*DIM; w++) begin
      res[w] = '0;
      for (int j = 0; j < 4; j++) begin
        int acc, col;
        col = (w % 2) * 4 + j;
        acc = int'($signed(c[w][16*j +: 16]));
        for (int k = 0; k < DIM; k++)
          acc += int'($signed(a[w/2][8*k +: 8])) * int'($signed(b[k][8*col +: 8]));
        res[w][16*j +: 16] = 16'(acc);
      end
    end
    return res;
  endfunction

  mat_t a_mem, b_mem;
  cw_t  c_mem, prod;

  always_comb prod = matmul(a_mem, b_mem, c_mem);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DIM; i++) begin a_mem[i] <= '0; b_mem[i] <= '0; end
      for (int i = 0; i < 2*DIM; i++) c_mem[i] <= '0;
    end else if (bus_r_w) begin
      case (bus_addr[15:8])
        8'h01: a_mem[bus_addr[5:3]] <= bus_wdata;
        8'h02: b_mem[bus_addr[5:3]] <= bus_wdata;
        8'h03: c_mem[bus_addr[6:3]] <= bus_wdata;
        8'h04: for (int i = 0; i < 2*DIM; i++) c_mem[i] <= prod[i];
        default: ;
      endcase
    end
  end

  always_comb begin
    bus_rdata = '0;
    if (bus_addr[15:7] == 9'h006) bus_rdata = c_mem[bus_addr[6:3]];
  end

  task automatic run_job(input int iv_mode, input int or_mode, input bit poke, input int abort_at,
                         input mat_t a, input mat_t b, input cw_t c, output int done_cyc);
    logic [63:0] words[$];
    tx_t  exp_tx[$];
    tx_t  got_tx[$];
    cw_t  res;
    cyc_t e;
    int   cyc, idx, trig, stall, t, n_idle, busy_low, bad_idle;
    bit   stalled;
    for (int k = 0; k < DIM; k++) words.push_back(a[k]);
    for (int k = 0; k < DIM; k++) words.push_back(b[k]);
    for (int k = 0; k < 2*DIM; k++) words.push_back(c[k]);
    for (int k = 0; k < DIM; k++) exp_tx.push_back('{1'b1, 16'(16'h0100 + 8*k), a[k]});
    for (int k = 0; k < DIM; k++) exp_tx.push_back('{1'b1, 16'(16'h0200 + 8*k), b[k]});
    for (int k = 0; k < 2*DIM; k++) exp_tx.push_back('{1'b1, 16'(16'h0300 + 8*k), c[k]});
    exp_tx.push_back('{1'b1, 16'h0400, 64'h0});
    for (int k = 0; k < 2*DIM; k++) exp_tx.push_back('{1'b0, 16'(16'h0300 + 8*k), 64'h0});
    log_q.delete();
    acc_q.delete();

    @(posedge clk); #1;
    start = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("busy_in_start_cycle", 128'(busy), 128'(0));
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0; idx = 0; trig = -1; done_cyc = -1; stall = 0; stalled = 1'b0;
    while (cyc < 3000 && done_cyc < 0) begin
      case (iv_mode)
        0: in_valid = (idx < NW);
        1: in_valid = (idx < NW) && (cyc % 2 == 0);
        default: in_valid = 1'($urandom_range(0, 1));
      endcase
      in_data = (in_valid && idx < NW) ? words[idx] : {$urandom, $urandom};
      if (or_mode == 1 && !stalled && acc_q.size() == 5) begin stalled = 1'b1; stall = 10; end
      case (or_mode)
        1: begin out_ready = (stall == 0); if (stall > 0) stall--; end
        2: out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b1;
      endcase
      start = poke && trig >= 0 && cyc >= trig + 3 && cyc <= trig + 5;
      @(negedge clk);
      e = '{bus_r_w, bus_addr, bus_wdata, in_valid, out_valid, out_ready, out_data, done, busy};
      log_q.push_back(e);
      if (in_valid && in_ready) idx++;
      if (out_valid && out_ready) acc_q.push_back(out_data);
      if (bus_r_w && bus_addr == 16'h0400) trig = cyc;
      if (done) done_cyc = cyc;
      if (abort_at >= 0 && idx == abort_at) break;
      @(posedge clk); #1;
      cyc++;
    end

    if (abort_at >= 0) begin
      check("abort_point", 128'(idx), 128'(abort_at));
      @(posedge clk); #1;
      in_valid = 1'b1; in_data = words[idx];
      #1;
      check("write_before_reset", 128'({bus_r_w, bus_addr, bus_wdata}),
            128'({1'b1, 16'(16'h0200 + 8*(abort_at - DIM)), words[idx]}));
      rst_n = 1'b0;
      #1;
      check("async_reset_values",
            128'({busy, in_ready, out_valid, done, bus_r_w, bus_addr, bus_wdata, out_data}), 128'(0));
      repeat (3) begin
        @(negedge clk);
        check("reset_held_idle", 128'({busy, in_ready, bus_r_w, bus_addr}), 128'(0));
      end
      @(posedge clk); #1;
      in_valid = 1'b0; rst_n = 1'b1;
      done_cyc = -2;
      return;
    end

    if (done_cyc < 0) begin
      total++; bad++;
      $display("FAIL job_timeout: got no done within %0d cycles", cyc);
    end

    t = -1; busy_low = 0; bad_idle = 0;
    for (int i = 0; i < log_q.size(); i++) begin
      e = log_q[i];
      if (e.rw || e.addr != 0) got_tx.push_back('{e.rw, e.addr, e.rw ? e.wdata : 64'h0});
      if (!e.by) busy_low++;
      if (!e.rw && e.addr == 0 && e.wdata != 0) bad_idle++;
      if (e.rw && e.addr[15:8] != 8'h04) check("write_has_valid", 128'(e.iv), 128'(1));
      if (e.rw && e.addr[15:8] == 8'h03)
        check("c_write_then_gap", (i + 1 < log_q.size()) ? 128'({log_q[i+1].rw, log_q[i+1].addr}) : 128'h1ffff, 128'(0));
      if (!e.rw && e.addr[15:8] == 8'h03) check("no_read_while_full", 128'(e.ov && !e.ordy), 128'(0));
      if (e.ov && !e.ordy && i + 1 < log_q.size())
        check("out_hold", 128'({log_q[i+1].ov, log_q[i+1].od}), 128'({1'b1, e.od}));
      if (e.rw && e.addr == 16'h0400) t = i;
    end
    check("tx_count", 128'(got_tx.size()), 128'(exp_tx.size()));
    for (int i = 0; i < got_tx.size() && i < exp_tx.size(); i++)
      check($sformatf("tx%0d", i), 128'(got_tx[i]), 128'(exp_tx[i]));
    check("busy_through_job", 128'(busy_low), 128'(0));
    check("idle_wdata_zero", 128'(bad_idle), 128'(0));
    if (t >= 0) begin
      n_idle = 0;
      while (t + 1 + n_idle < log_q.size() && !log_q[t+1+n_idle].rw && log_q[t+1+n_idle].addr == 0) n_idle++;
      check("mul_wait_len", 128'(n_idle), 128'(MUL_WAIT));
    end
    res = matmul(a, b, c);
    check("out_count", 128'(acc_q.size()), 128'(2*DIM));
    for (int k = 0; k < acc_q.size() && k < 2*DIM; k++)
      check($sformatf("out%0d", k), 128'(acc_q[k]), 128'(res[k]));

    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("idle_after_done", 128'({busy, done, bus_r_w, bus_addr, out_valid}), 128'(0));
  endtask

  initial begin
    vec_t vt[11];
    mat_t a, b;
    cw_t  c;
    int   dc;
    logic [63:0] w;

    for (int i = 0; i < 5; i++) vt[i] = '{1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 16'h0, 64'h0};
    vt[5]  = '{1'b1, 1'b0, 64'hdead_beef_0000_0001, 1'b0, 1'b0, 1'b0, 16'h0000, 64'h0};
    vt[6]  = '{1'b0, 1'b1, 64'h1111_2222_3333_4444, 1'b1, 1'b1, 1'b1, 16'h0100, 64'h1111_2222_3333_4444};
    vt[7]  = '{1'b0, 1'b0, 64'h5555_6666_7777_8888, 1'b1, 1'b1, 1'b0, 16'h0000, 64'h0};
    vt[8]  = '{1'b0, 1'b1, 64'h9999_aaaa_bbbb_cccc, 1'b1, 1'b1, 1'b1, 16'h0108, 64'h9999_aaaa_bbbb_cccc};
    vt[9]  = '{1'b1, 1'b0, 64'h0123_4567_89ab_cdef, 1'b1, 1'b1, 1'b0, 16'h0000, 64'h0};
    vt[10] = '{1'b0, 1'b1, 64'hfedc_ba98_7654_3210, 1'b1, 1'b1, 1'b1, 16'h0110, 64'hfedc_ba98_7654_3210};

    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_values",
          128'({busy, done, in_ready, out_valid, out_data, bus_r_w, bus_addr, bus_wdata}), 128'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      @(posedge clk); #1;
      start = vt[i].start; in_valid = vt[i].iv; in_data = vt[i].data;
      @(negedge clk);
      check($sformatf("vec%0d", i),
            128'({busy, in_ready, bus_r_w, bus_addr, bus_wdata, out_valid, done}),
            128'({vt[i].by, vt[i].ir, vt[i].rw, vt[i].addr, vt[i].wdata, 1'b0, 1'b0}));
    end
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // identity A, B[r][c] = r*8+c, C = 0
    for (int r = 0; r < DIM; r++) begin
      a[r] = 64'(1) << (8*r);
      for (int col = 0; col < DIM; col++) b[r][8*col +: 8] = 8'(r*8 + col);
    end
    for (int k = 0; k < 2*DIM; k++) c[k] = '0;
    run_job(0, 0, 1'b0, -1, a, b, c, dc);
    check("done_latency", 128'(dc), 128'(88));
    for (int k = 0; k < 2*DIM && k < acc_q.size(); k++) begin
      for (int j = 0; j < 4; j++) w[16*j +: 16] = 16'((k/2)*8 + (k%2)*4 + j);
      check($sformatf("identity_out%0d", k), 128'(acc_q[k]), 128'(w));
    end

    for (int r = 0; r < DIM; r++) begin a[r] = {$urandom, $urandom}; b[r] = {$urandom, $urandom}; end
    for (int k = 0; k < 2*DIM; k++) c[k] = {$urandom, $urandom};
    run_job(1, 1, 1'b1, -1, a, b, c, dc);

    for (int r = 0; r < DIM; r++) begin a[r] = {$urandom, $urandom}; b[r] = {$urandom, $urandom}; end
    for (int k = 0; k < 2*DIM; k++) c[k] = {$urandom, $urandom};
    run_job(2, 2, 1'b0, -1, a, b, c, dc);

    run_job(0, 0, 1'b0, DIM + 3, a, b, c, dc);

    for (int r = 0; r < DIM; r++) begin a[r] = {$urandom, $urandom}; b[r] = {$urandom, $urandom}; end
    for (int k = 0; k < 2*DIM; k++) c[k] = {$urandom, $urandom};
    run_job(0, 0, 1'b0, -1, a, b, c, dc);
    check("restart_latency", 128'(dc), 128'(88));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
